// File: rtl/hex_scan_driver.sv
// Four-digit common-anode seven-segment scanner with frame-synchronous shadow load,
// brightness PWM, blanking and decimal points. Define HEX_SCAN_LZB_EN for leading-zero blanking.
module hex_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [2:0]  brightness,
    input  logic        blank,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   sh_hex;
    logic [3:0]    sh_dp;
    logic          init;
    logic          wrap;
    logic          load;
    logic [23:0]   on_lim;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic          suppress;
    logic          lit;

    assign wrap = (pcnt == PCNT_MAX);
    assign load = init || (wrap && (idx == 2'd3));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= 2'd0;
        end else if (wrap) begin
            pcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // init forces one capture on the first edge after reset so the display never shows stale zeros for a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_hex <= 16'h0000;
            sh_dp  <= 4'h0;
            init   <= 1'b1;
        end else if (load) begin
            sh_hex <= hex_in;
            sh_dp  <= dp_in;
            init   <= 1'b0;
        end
    end

    assign on_lim = ((24'(brightness) + 24'd1) * 24'(CLK_DIV)) / 24'd8 - 24'd1;
    assign nib    = sh_hex[4*idx +: 4];

    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

`ifdef HEX_SCAN_LZB_EN
    // a digit goes dark when it and every digit to its left hold zero; digit 0 always shows
    always_comb begin
        suppress = 1'b0;
        case (idx)
            2'd1: suppress = (sh_hex[15:4] == 12'h000);
            2'd2: suppress = (sh_hex[15:8] == 8'h00);
            2'd3: suppress = (sh_hex[15:12] == 4'h0);
            default: suppress = 1'b0;
        endcase
    end
`else
    assign suppress = 1'b0;
`endif

    // pcnt==0 stays dark so the previous digit's segments never ghost onto the next anode
    assign lit = (pcnt != '0) && (24'(pcnt) <= on_lim) && !blank && !suppress;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= load;
            if (lit) begin
                seg_n <= glyph;
                dp_n  <= ~sh_dp[idx];
                an_n  <= ~(4'b0001 << idx);
            end else begin
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
                an_n  <= 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: a frame/slot arithmetic model checked every cycle,
// plus literal glyph/anode expectations at chosen scan positions.
module tb_hex_scan_driver;

    localparam int D = 8;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] hex_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [2:0]  brightness = 3'd7;
    logic        blank = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    int          n = 0;
    logic [15:0] m_hex = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [3:0]  e_an = 4'hF;
    logic        e_tick = 1'b0;

    hex_scan_driver #(.CLK_DIV(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .brightness (brightness),
        .blank      (blank),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // What the pins must show for the scan position reached after nn edges since reset release
    function automatic logic [11:0] model_out(input int nn, input logic [15:0] hx, input logic [3:0] dps,
                                              input logic [2:0] br, input logic bl);
        int   slot_pos;
        int   digit;
        int   lim;
        bit   on;
        logic [3:0] an;
        slot_pos = nn % D;
        digit    = (nn / D) % 4;
        lim      = ((int'(br) + 1) * D) / 8 - 1;
        on       = (slot_pos >= 1) && (slot_pos <= lim) && !bl;
`ifdef HEX_SCAN_LZB_EN
        if (digit > 0 && (hx >> (4 * digit)) == 16'h0000) on = 1'b0;
`endif
        an        = 4'hF;
        an[digit] = 1'b0;
        if (on) return {GLYPH[hx[4*digit +: 4]], ~dps[digit], an};
        return {7'h7F, 1'b1, 4'hF};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n      <= 0;
            m_hex  <= 16'h0000;
            m_dp   <= 4'h0;
            e_seg  <= 7'h7F;
            e_dp   <= 1'b1;
            e_an   <= 4'hF;
            e_tick <= 1'b0;
        end else begin
            {e_seg, e_dp, e_an} <= model_out(n, m_hex, m_dp, brightness, blank);
            e_tick <= (n == 0) || ((n % (4 * D)) == 4 * D - 1);
            if ((n == 0) || ((n % (4 * D)) == 4 * D - 1)) begin
                m_hex <= hex_in;
                m_dp  <= dp_in;
            end
            n <= n + 1;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({seg_n, dp_n, an_n, frame_tick} !== {e_seg, e_dp, e_an, e_tick}) begin
            errors++;
            $display("[TB] FAIL cycle_model t=%0t: got seg=%h dp=%b an=%h tick=%b, want seg=%h dp=%b an=%h tick=%b",
                     $time, seg_n, dp_n, an_n, frame_tick, e_seg, e_dp, e_an, e_tick);
        end
    end

    task automatic applyStimulus(input logic [15:0] hx, input logic [3:0] dps,
                                 input logic [2:0] br, input logic bl);
        hex_in     = hx;
        dp_in      = dps;
        brightness = br;
        blank      = bl;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] x_seg, input logic [3:0] x_an,
                               input logic x_dp, input logic x_tick);
        checks++;
        if ({seg_n, an_n, dp_n, frame_tick} !== {x_seg, x_an, x_dp, x_tick}) begin
            errors++;
            $display("[TB] FAIL %s: got seg=%h an=%h dp=%b tick=%b, want seg=%h an=%h dp=%b tick=%b",
                     name, seg_n, an_n, dp_n, frame_tick, x_seg, x_an, x_dp, x_tick);
        end
    endtask

    // Advance to the next negedge where the pins display digit wi at prescaler position wp
    task automatic wait_slot(input int wi, input int wp);
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (n >= 1 && ((n - 1) % D) == wp && (((n - 1) / D) % 4) == wi) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_slot idx=%0d pcnt=%0d: not reached, want reached", wi, wp);
        end
        #1;
    endtask

    initial begin
        int lit_cycles;
        #1 reset = 1'b1;
        applyStimulus(16'h0000, 4'h0, 3'd7, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_hold", 7'h7F, 4'hF, 1'b1, 1'b0);

        applyStimulus(16'h12AF, 4'h0, 3'd7, 1'b0);
        reset = 1'b0;
        wait_slot(0, 1); checkOutput("first_idx0", 7'h0E, 4'hE, 1'b1, 1'b0);
        wait_slot(1, 1); checkOutput("first_idx1", 7'h08, 4'hD, 1'b1, 1'b0);
        wait_slot(2, 1); checkOutput("first_idx2", 7'h24, 4'hB, 1'b1, 1'b0);
        wait_slot(3, 0); checkOutput("dead_slot",  7'h7F, 4'hF, 1'b1, 1'b0);
        wait_slot(3, 7); checkOutput("first_idx3", 7'h79, 4'h7, 1'b1, 1'b1);

        applyStimulus(16'h1111, 4'h0, 3'd7, 1'b0);
        wait_slot(1, 4); checkOutput("old_frame_A", 7'h08, 4'hD, 1'b1, 1'b0);
        wait_slot(1, 4); checkOutput("ones_idx1",   7'h79, 4'hD, 1'b1, 1'b0);
        applyStimulus(16'h2222, 4'h0, 3'd7, 1'b0);
        wait_slot(2, 3); checkOutput("no_tear_idx2", 7'h79, 4'hB, 1'b1, 1'b0);
        wait_slot(3, 6); checkOutput("no_tear_idx3", 7'h79, 4'h7, 1'b1, 1'b0);
        wait_slot(3, 7); checkOutput("frame_tick",   7'h79, 4'h7, 1'b1, 1'b1);
        wait_slot(0, 2); checkOutput("twos_idx0",    7'h24, 4'hE, 1'b1, 1'b0);
        wait_slot(3, 2); checkOutput("twos_idx3",    7'h24, 4'h7, 1'b1, 1'b0);

        applyStimulus(16'h2222, 4'h0, 3'd0, 1'b0);
        lit_cycles = 0;
        for (int k = 0; k < 4 * D; k++) begin
            @(negedge clk);
            if (an_n !== 4'hF) lit_cycles++;
        end
        #1;
        checks++;
        if (lit_cycles != 0) begin
            errors++;
            $display("[TB] FAIL bright0_dark: got %0d lit cycles, want 0", lit_cycles);
        end
        applyStimulus(16'h2222, 4'h0, 3'd3, 1'b0);
        wait_slot(1, 3); checkOutput("bright3_on",  7'h24, 4'hD, 1'b1, 1'b0);
        wait_slot(1, 4); checkOutput("bright3_off", 7'h7F, 4'hF, 1'b1, 1'b0);

        applyStimulus(16'h2222, 4'h0, 3'd7, 1'b0);
        wait_slot(2, 2); checkOutput("pre_blank", 7'h24, 4'hB, 1'b1, 1'b0);
        applyStimulus(16'h2222, 4'h0, 3'd7, 1'b1);
        @(negedge clk); #1;
        checkOutput("blank_next", 7'h7F, 4'hF, 1'b1, 1'b0);
        wait_slot(3, 3); checkOutput("blank_hold", 7'h7F, 4'hF, 1'b1, 1'b0);
        applyStimulus(16'h2222, 4'h0, 3'd7, 1'b0);
        wait_slot(0, 3); checkOutput("blank_resume", 7'h24, 4'hE, 1'b1, 1'b0);

        applyStimulus(16'h0005, 4'b0100, 3'd7, 1'b0);
        wait_slot(3, 7);
        wait_slot(0, 1); checkOutput("dp_idx0", 7'h12, 4'hE, 1'b1, 1'b0);
`ifdef HEX_SCAN_LZB_EN
        wait_slot(1, 1); checkOutput("lzb_idx1", 7'h7F, 4'hF, 1'b1, 1'b0);
        wait_slot(2, 1); checkOutput("lzb_idx2", 7'h7F, 4'hF, 1'b1, 1'b0);
        wait_slot(3, 1); checkOutput("lzb_idx3", 7'h7F, 4'hF, 1'b1, 1'b0);
`else
        wait_slot(1, 1); checkOutput("zero_idx1", 7'h40, 4'hD, 1'b1, 1'b0);
        wait_slot(2, 1); checkOutput("dp_idx2",   7'h40, 4'hB, 1'b0, 1'b0);
        wait_slot(3, 1); checkOutput("zero_idx3", 7'h40, 4'h7, 1'b1, 1'b0);
`endif

        wait_slot(3, 4);
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 7'h7F, 4'hF, 1'b1, 1'b0);
        applyStimulus(16'h00C0, 4'b0100, 3'd7, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;
        wait_slot(0, 1); checkOutput("restart_idx0", 7'h40, 4'hE, 1'b1, 1'b0);
        wait_slot(1, 1); checkOutput("restart_idx1", 7'h46, 4'hD, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the hex-digit PIO. It consumes the PIO's 16-bit output word (four hex nibbles) and scans it onto a common-anode display, one digit per slot. The displayed value updates only at frame boundaries, so the display never tears. The block supports brightness PWM, a global blank, per-digit decimal points and optional leading-zero blanking.

## Interface
Parameters:
- CLK_DIV, 50000: clk cycles per digit slot. Legal range is 8 to 2^20. The default gives 250 Hz frame refresh at 50 MHz.

Ports:
- clk  in  1  system clock; all logic is synchronous to its rising edge.
- reset  in  1  asynchronous reset, active-high.
- hex_in  in  16  value from the PIO's out_port. Nibble k drives digit k; digit 0 is the rightmost.
- dp_in  in  4  decimal-point request per digit, active-high.
- brightness  in  3  PWM level, 0 to 7. 7 is full on.
- blank  in  1  forces all anodes off while high.
- seg_n  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- an_n  out  4  active-low digit enables.
- frame_tick  out  1  one-cycle pulse on each shadow-register load.

## Operation
- Prescaler `pcnt` counts 0 to CLK_DIV-1, then wraps. At wrap, digit index `idx` advances 0→1→2→3→0.
- Shadow registers `sh_hex` (16 bits) and `sh_dp` (4 bits) capture hex_in and dp_in:
  - in the cycle where `pcnt` wraps with `idx`=3 (frame end);
  - in the first clk edge after reset deasserts (an init flag is set by reset and cleared by that load).
- frame_tick goes high in the cycle following each load.
- Decode uses `sh_hex[4*idx+3:4*idx]` with the standard hex glyphs:
  - seg_n values: 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10, A→0x08, b→0x03, C→0x46, d→0x21, E→0x06, F→0x0E.
- On-window: on_lim = ((brightness+1)*CLK_DIV)/8 - 1, computed with a 24-bit intermediate and truncating division. The digit is on when 1 ≤ `pcnt` ≤ on_lim.
- `pcnt`=0 is always a dead cycle with all anodes off (anti-ghosting).
- When on: an_n = ~(4'b0001 << idx); dp_n = ~sh_dp[idx].
- When off (outside the window, blank=1, or digit suppressed): an_n=4'hF, dp_n=1, seg_n=7'h7F.
- brightness and blank are sampled every cycle; changing them mid-slot takes effect immediately, subject to the output register.
- Reset mid-scan: all counters, shadows and outputs return to their reset values at once. Scanning restarts at idx=0, `pcnt`=0.

## Timing
- All outputs are registered. Each output reflects the state of `pcnt`, `idx` and the shadow registers one clk after that state.
- Reset values: seg_n=7'h7F, dp_n=1, an_n=4'hF, frame_tick=0, `pcnt`=0, `idx`=0, `sh_hex`=0, `sh_dp`=0.
- Slot period is CLK_DIV cycles; frame period is 4*CLK_DIV cycles.
- hex_in changes reach the pins at most 4*CLK_DIV+2 cycles later. No change appears mid-frame.
- A hex_in change coincident with the frame-end load is captured in that load.
- No handshake: hex_in is a level held by the PIO register, which is in the same clock domain.

## Configuration
- HEX_SCAN_LZB_EN defined: leading-zero blanking is enabled.
  - Digit k (k=1..3) is suppressed when sh_hex nibbles k..3 are all zero. A suppressed digit shows no segments and no decimal point.
  - Digit 0 is never suppressed.
- HEX_SCAN_LZB_EN undefined: all four digits always display, including leading zeros. The suppression logic is not compiled.

## Test plan
Sim with CLK_DIV=8.
- Reset held, then released with hex_in=16'h12AF, brightness=7. While reset is held: an_n=F, seg_n=7F. First frame after release: idx0 shows seg_n=0x0E with an_n=E; idx1 0x08/D; idx2 0x24/B; idx3 0x79/7. Each digit is lit for pcnt 1..7 only.
- hex_in changes from 16'h1111 to 16'h2222 mid-frame (during idx=1). The remainder of the frame still shows 1s. Frame_tick pulses at the frame end. The next frame shows seg_n=0x24 on all digits.
- brightness=0: on_lim=0, so no digit ever lights (an_n stays F). brightness=3: digit on for pcnt 1..3 only.
- blank asserted during idx=2: an_n=F from the next cycle. Scanning position continues; after release, display resumes at the correct idx.
- dp_in=4'b0100 with hex_in=16'h0005:
  - HEX_SCAN_LZB_EN undefined: digits 3,2,1 show 0x40; dp_n is low only on digit 2; digit 0 shows 0x12.
  - HEX_SCAN_LZB_EN defined: digits 1–3 dark with dp_n=1 (digit 2's dp suppressed too); digit 0 shows 0x12.
- Reset pulsed for 1 cycle while idx=3, pcnt=5: all outputs go to reset values asynchronously. Scan restarts at idx=0. Shadow reloads on the first edge after release.
